// File: rtl/weight_loader_pkg.sv
// Shared NPU package: HP stream / weight-memory geometry
// defaults and the weight loader state encoding.
package weight_loader_pkg;

  localparam int WL_AXI_HP_BIT = 64;
  localparam int WL_ADDR_WIDTH = 14;
  localparam int WL_CNT_WIDTH  = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } wl_state_e;

  // A burst is well framed only when s_last and the
  // count-derived final beat agree; any mismatch is an error.
  function automatic logic frame_err(
    input logic final_beat,
    input logic last
  );
    return final_beat ^ last;
  endfunction

endpackage

// File: rtl/weight_loader.sv
// Weight loader: streams HP beats into weight memory.
// Ports: clk, rst_n (sync, active-low); start/base_addr/
// num_beats launch a load; s_valid/s_data/s_last/s_ready
// form the beat stream; wr_en/wr_addr/wr_data drive the
// weight-memory write port; busy, done, err report status.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int AXI_HP_BIT = WL_AXI_HP_BIT,
  parameter int ADDR_WIDTH = WL_ADDR_WIDTH,
  parameter int CNT_WIDTH  = WL_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_beats,
  input  logic                  s_valid,
  input  logic [AXI_HP_BIT-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [AXI_HP_BIT-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  wl_state_e             state;
  wl_state_e             state_nxt;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [CNT_WIDTH-1:0]  rem_cnt;
  logic [CNT_WIDTH-1:0]  rem_nxt;
  logic                  err_nxt;
  logic                  wr_en_nxt;
  logic [ADDR_WIDTH-1:0] wr_addr_nxt;
  logic [AXI_HP_BIT-1:0] wr_data_nxt;
  logic                  beat;
  logic                  final_beat;

  assign s_ready = (state == LOAD);
  assign busy    = (state != IDLE);
  // DONE is entered on the edge that registers the final
  // write, so done lines up with that write's wr_en.
  assign done    = (state == DONE);

  assign beat       = s_valid & s_ready;
  assign final_beat = (rem_cnt == CNT_WIDTH'(1));

  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr_cnt;
    rem_nxt     = rem_cnt;
    err_nxt     = err;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr;
    wr_data_nxt = wr_data;
    unique case (state)
      IDLE: begin
        if (start) begin
          err_nxt  = 1'b0;
          addr_nxt = base_addr;
          rem_nxt  = num_beats;
          if (num_beats == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        if (beat) begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = addr_cnt;
          wr_data_nxt = s_data;
          // Wraps naturally at 2^ADDR_WIDTH.
          addr_nxt    = addr_cnt + ADDR_WIDTH'(1);
          rem_nxt     = rem_cnt - CNT_WIDTH'(1);
          if (final_beat || s_last) begin
            state_nxt = DONE;
          end
          if (frame_err(final_beat, s_last)) begin
            err_nxt = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_cnt <= '0;
      rem_cnt  <= '0;
      err      <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state    <= state_nxt;
      addr_cnt <= addr_nxt;
      rem_cnt  <= rem_nxt;
      err      <= err_nxt;
      wr_en    <= wr_en_nxt;
      wr_addr  <= wr_addr_nxt;
      wr_data  <= wr_data_nxt;
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: directed steps, write
// scoreboard checked one cycle after each accepted beat.
module tb_weight_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [13:0] base_addr;
  logic [14:0] num_beats;
  logic        s_valid;
  logic [63:0] s_data;
  logic        s_last;
  logic        s_ready;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [63:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct {
    logic [13:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  failures = 0;
  int  done_seen = 0;

  always #5 clk = ~clk;

  weight_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .num_beats (num_beats),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (done === 1'b1) done_seen++;
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_wr", 64'(wr_en), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(e.addr));
        chk("wr_data", wr_data, e.data);
      end
    end
  endtask

  task automatic push(
    input logic [13:0] a,
    input logic [63:0] d
  );
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  function automatic logic [63:0] pat(input int t, input int i);
    return 64'hD0D0_0000_0000_0000 + 64'(t) * 64'h100 + 64'(i);
  endfunction

  initial begin
    int          k;
    int          d0;
    logic [13:0] a;

    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    num_beats = '0;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    tick();
    tick();
    chk("rst_ready", 64'(s_ready), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    tick();

    // Back-to-back burst at 0x10.
    start = 1'b1;
    base_addr = 14'h0010;
    num_beats = 15'd4;
    tick();
    start = 1'b0;
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_ready", 64'(s_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data = pat(1, i);
      s_last = (i == 3);
      push(14'h0010 + 14'(i), pat(1, i));
      tick();
      chk("t1_lat", 64'(sb.size()), 64'd0);
      if (i < 3) chk("t1_done_early", 64'(done), 64'd0);
    end
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_done_wr", 64'(wr_en), 64'd1);
    chk("t1_err", 64'(err), 64'd0);
    s_valid = 1'b0;
    s_last = 1'b0;
    tick();
    chk("t1_done_off", 64'(done), 64'd0);
    chk("t1_idle", 64'(busy), 64'd0);

    // Address wrap with gapped valid.
    d0 = done_seen;
    start = 1'b1;
    base_addr = 14'h3FFE;
    num_beats = 15'd4;
    tick();
    start = 1'b0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      if (c % 2 == 0) begin
        s_valid = 1'b1;
        s_data = pat(2, k);
        s_last = (k == 3);
        a = 14'h3FFE + 14'(k);
        push(a, pat(2, k));
        k++;
      end else begin
        s_valid = 1'b0;
        s_data = 64'hDEAD_BEEF_0000_0000;
        s_last = 1'b0;
      end
      tick();
      chk("t2_lat", 64'(sb.size()), 64'd0);
    end
    chk("t2_done_once", 64'(done_seen - d0), 64'd1);

    // Early s_last on beat 2 of 4.
    start = 1'b1;
    base_addr = 14'h0100;
    num_beats = 15'd4;
    tick();
    start = 1'b0;
    s_valid = 1'b1;
    s_data = pat(3, 0);
    s_last = 1'b0;
    push(14'h0100, pat(3, 0));
    tick();
    s_data = pat(3, 1);
    s_last = 1'b1;
    push(14'h0101, pat(3, 1));
    tick();
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_wr", 64'(wr_en), 64'd1);
    chk("t3_err", 64'(err), 64'd1);
    s_data = 64'hBAD0_BAD0_BAD0_BAD0;
    s_last = 1'b0;
    tick();
    chk("t3_err_hold", 64'(err), 64'd1);
    chk("t3_idle", 64'(busy), 64'd0);
    chk("t3_ready", 64'(s_ready), 64'd0);
    tick();
    chk("t3_err_hold2", 64'(err), 64'd1);
    s_valid = 1'b0;

    // Zero-length load.
    start = 1'b1;
    base_addr = 14'h0055;
    num_beats = 15'd0;
    tick();
    start = 1'b0;
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_busy", 64'(busy), 64'd1);
    chk("t4_ready", 64'(s_ready), 64'd0);
    chk("t4_wr", 64'(wr_en), 64'd0);
    chk("t4_err_clr", 64'(err), 64'd0);
    tick();
    chk("t4_done_off", 64'(done), 64'd0);
    chk("t4_idle", 64'(busy), 64'd0);

    // Final beat without s_last.
    start = 1'b1;
    base_addr = 14'h0020;
    num_beats = 15'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data = pat(5, i);
      s_last = 1'b0;
      push(14'h0020 + 14'(i), pat(5, i));
      tick();
    end
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_err", 64'(err), 64'd1);
    s_valid = 1'b0;
    tick();

    // Reset after 2 of 8 beats.
    start = 1'b1;
    base_addr = 14'h0200;
    num_beats = 15'd8;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data = pat(6, i);
      s_last = 1'b0;
      push(14'h0200 + 14'(i), pat(6, i));
      tick();
    end
    rst_n = 1'b0;
    s_data = pat(6, 2);
    tick();
    chk("t6_wr", 64'(wr_en), 64'd0);
    chk("t6_addr", 64'(wr_addr), 64'd0);
    chk("t6_data", wr_data, 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    chk("t6_err", 64'(err), 64'd0);
    chk("t6_ready", 64'(s_ready), 64'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("t6_quiet", 64'(busy), 64'd0);
    s_valid = 1'b0;
    start = 1'b1;
    base_addr = 14'h0040;
    num_beats = 15'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data = pat(7, i);
      s_last = (i == 1);
      push(14'h0040 + 14'(i), pat(7, i));
      tick();
    end
    chk("t6_reload_done", 64'(done), 64'd1);
    chk("t6_reload_err", 64'(err), 64'd0);
    s_valid = 1'b0;
    s_last = 1'b0;
    tick();

    // Start during LOAD and DONE is ignored.
    start = 1'b1;
    base_addr = 14'h0080;
    num_beats = 15'd3;
    tick();
    start = 1'b0;
    s_valid = 1'b1;
    s_data = pat(8, 0);
    push(14'h0080, pat(8, 0));
    tick();
    start = 1'b1;
    base_addr = 14'h0500;
    num_beats = 15'd5;
    s_data = pat(8, 1);
    push(14'h0081, pat(8, 1));
    tick();
    s_data = pat(8, 2);
    s_last = 1'b1;
    push(14'h0082, pat(8, 2));
    tick();
    chk("t7_done", 64'(done), 64'd1);
    chk("t7_err", 64'(err), 64'd0);
    s_valid = 1'b0;
    s_last = 1'b0;
    base_addr = 14'h0600;
    num_beats = 15'd2;
    tick();
    start = 1'b0;
    chk("t7_ign_done", 64'(busy), 64'd0);
    tick();
    chk("t7_idle", 64'(busy), 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 Parameter AXI_HP_BIT, default 64: HP stream beat width and weight-memory word width.
REQ-002 Parameter ADDR_WIDTH, default 14: weight-memory word address width.
REQ-003 Parameter CNT_WIDTH, default 15: beat-count width; must hold 2^ADDR_WIDTH.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  one-cycle pulse; begins a load when idle.
REQ-007 base_addr  input  ADDR_WIDTH  first write address; sampled on accepted start.
REQ-008 num_beats  input  CNT_WIDTH  beats to load; sampled on accepted start.
REQ-009 s_valid  input  1  stream beat valid.
REQ-010 s_data  input  AXI_HP_BIT  stream beat payload.
REQ-011 s_last  input  1  marks final beat of the DMA burst.
REQ-012 s_ready  output  1  loader accepts a beat this cycle.
REQ-013 wr_en  output  1  weight-memory write strobe.
REQ-014 wr_addr  output  ADDR_WIDTH  weight-memory write address.
REQ-015 wr_data  output  AXI_HP_BIT  weight-memory write data.
REQ-016 busy  output  1  load in progress.
REQ-017 done  output  1  one-cycle pulse at load completion.
REQ-018 err  output  1  sticky framing error; cleared by next accepted start.

Function
REQ-019 FSM states IDLE, LOAD, DONE; reset and default state IDLE.
REQ-020 IDLE: start=1 with num_beats>0 -> LOAD, latch base_addr into address counter, num_beats into remaining counter, clear err.
REQ-021 IDLE: start=1 with num_beats=0 -> DONE directly; no writes; err cleared.
REQ-022 start while in LOAD or DONE is ignored.
REQ-023 s_ready = 1 only in LOAD; beat accepted when s_valid & s_ready.
REQ-024 Accepted beat -> next cycle wr_en=1, wr_addr=current address counter, wr_data=s_data (one-cycle registered latency, one write per beat, no drops).
REQ-025 Address counter increments by 1 per accepted beat, modulo 2^ADDR_WIDTH (0x3FFF -> 0x0000).
REQ-026 Remaining counter decrements per accepted beat; beat with remaining=1 is final -> LOAD to DONE.
REQ-027 s_last on a non-final beat: beat is written, err set, LOAD to DONE (early termination).
REQ-028 Final beat without s_last: beat is written, err set, LOAD to DONE.
REQ-029 DONE lasts exactly one cycle: done=1, then IDLE; done coincides with wr_en of final beat's write.
REQ-030 busy = 1 in LOAD and DONE, 0 in IDLE.
REQ-031 wr_en=0 whenever no beat was accepted in the previous cycle; wr_addr/wr_data hold last value.
REQ-032 s_valid without s_ready is held off; beats outside LOAD are never consumed.

Reset
REQ-033 rst_n=0 at a clock edge: state IDLE, s_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, counters=0.
REQ-034 Reset mid-LOAD aborts the load; no write is issued in the cycle after reset; done not pulsed.

Structure
REQ-035 Shared NPU package holds AXI_HP_BIT, ADDR_WIDTH, CNT_WIDTH defaults and the loader state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2).
REQ-036 Single flat module; no sub-module; outputs wr_en/wr_addr/wr_data connect directly to the weight-memory write port.

Verification
REQ-037 start, base=0x0010, num=4, 4 back-to-back beats D0..D3, s_last on D3 -> writes 0x10..0x13 with D0..D3, each one cycle after acceptance, done on last write, err=0.
REQ-038 base=0x3FFE, num=4, s_valid toggled every other cycle -> writes at 0x3FFE,0x3FFF,0x0000,0x0001 only on accepted beats, done once.
REQ-039 num=4, s_last on beat 2 -> 2 writes, done after 2nd write, err=1 until next start.
REQ-040 num=0 start -> done one cycle later, no wr_en, s_ready never 1.
REQ-041 rst_n=0 after 2 of 8 beats -> all outputs zero next cycle, no further writes; new start from IDLE loads normally.
REQ-042 start pulsed during LOAD with different base -> ignored, addresses continue from original base.
